// File: rtl/neuron_pkg.sv
// rtl/neuron_pkg.sv - shared types and helpers for the LIF neuron
package neuron_pkg;

  typedef enum logic {
    INTEG  = 1'b0,
    REFRAC = 1'b1
  } state_t;

  localparam int ADAPT_STEP = 16;
  localparam int TH_OFF_MAX = 255;

  function automatic logic [6:0] popcount(input logic [63:0] v);
    logic [6:0] c;
    c = '0;
    for (int i = 0; i < 64; i++) c = c + {6'd0, v[i]};
    return c;
  endfunction

  // a + b clipped to [lo, hi]; callers keep operands far below 64-bit overflow
  function automatic longint sat_add(input longint a, input longint b,
                                     input longint lo, input longint hi);
    longint s;
    s = a + b;
    if (s < lo) s = lo;
    else if (s > hi) s = hi;
    return s;
  endfunction

endpackage

// File: rtl/neuron_tick_gen.sv
// rtl/neuron_tick_gen.sv - one-clk tick pulse every TICK_DIV clocks
module neuron_tick_gen #(
  parameter int TICK_DIV = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_cnt;

  // first tick lands on the TICK_DIV-th edge after reset release
  assign o_tick = (r_cnt == LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/lif_neuron_n.sv
// rtl/lif_neuron_n.sv - parametrised leaky integrate-and-fire neuron
// NEURON_ADAPT_EN enables the decaying adaptive threshold offset.
module lif_neuron_n
  import neuron_pkg::*;
#(
  parameter int N_EX         = 4,
  parameter int N_IN         = 4,
  parameter int VW           = 12,
  parameter int W_EX         = 8,
  parameter int W_IN         = 8,
  parameter int THRESH       = 100,
  parameter int V_RESET      = 0,
  parameter int V_MIN        = -256,
  parameter int LEAK_SHIFT   = 4,
  parameter int TICK_DIV     = 4,
  parameter int REFRAC_TICKS = 5,
  parameter int LED_HOLD     = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_EX-1:0] ex,
  input  logic [N_IN-1:0] inh,
  output logic            spike,
  output logic            led,
  output logic [VW-1:0]   v_mem
);

  localparam int CW   = $clog2(N_EX + N_IN);
  localparam int WIDE = VW + CW + 8;
  localparam int VMAX = 2 ** (VW - 1) - 1;
  localparam int RW   = (REFRAC_TICKS > 1) ? $clog2(REFRAC_TICKS + 1) : 1;
  localparam int LW   = (LED_HOLD > 1) ? $clog2(LED_HOLD + 1) : 1;

  localparam logic signed [WIDE-1:0] W_EX_W    = WIDE'(W_EX);
  localparam logic signed [WIDE-1:0] W_IN_W    = WIDE'(W_IN);
  localparam logic signed [VW-1:0]   V_RESET_V = VW'(V_RESET);
  localparam logic [RW-1:0]          REFRAC_LD = RW'(REFRAC_TICKS);
  localparam logic [LW-1:0]          LED_LD    = LW'(LED_HOLD);
  localparam logic                   HAS_REFRAC = (REFRAC_TICKS > 0);
  localparam logic                   LED_ON     = (LED_HOLD > 0);

  logic                   w_tick;
  logic [6:0]             w_ex_cnt;
  logic [6:0]             w_in_cnt;
  logic signed [WIDE-1:0] w_v_ext;
  logic signed [WIDE-1:0] w_leak;
  logic signed [WIDE-1:0] w_ex_term;
  logic signed [WIDE-1:0] w_in_term;
  logic signed [WIDE-1:0] w_base;
  logic signed [WIDE-1:0] w_stim;
  logic signed [63:0]     w_sat;
  logic signed [63:0]     w_thr;
  logic signed [VW-1:0]   w_v_next;
  logic                   w_fire;

  state_t               r_state;
  logic signed [VW-1:0] r_v;
  logic                 r_spike;
  logic                 r_led;
  logic [RW-1:0]        r_refrac;
  logic [LW-1:0]        r_led_cnt;

  neuron_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .i_clk   (clk),
    .i_rst_n (reset),
    .o_tick  (w_tick)
  );

  assign w_ex_cnt  = popcount(64'(ex));
  assign w_in_cnt  = popcount(64'(inh));
  assign w_v_ext   = {{(WIDE - VW){r_v[VW-1]}}, r_v};
  assign w_leak    = w_v_ext >>> LEAK_SHIFT;
  assign w_ex_term = W_EX_W * $signed({{(WIDE - 7){1'b0}}, w_ex_cnt});
  assign w_in_term = W_IN_W * $signed({{(WIDE - 7){1'b0}}, w_in_cnt});
  assign w_base    = w_v_ext - w_leak;
  assign w_stim    = w_ex_term - w_in_term;
  assign w_sat     = sat_add(longint'(w_base), longint'(w_stim),
                             longint'(V_MIN), longint'(VMAX));
  assign w_v_next  = w_sat[VW-1:0];
  assign w_fire    = (r_state == INTEG) && (w_sat >= w_thr);

`ifdef NEURON_ADAPT_EN
  logic [7:0]         r_th_off;
  logic [7:0]         w_th_dec;
  logic signed [63:0] w_th_add;

  assign w_thr    = longint'(THRESH) + longint'(r_th_off);
  assign w_th_dec = (r_th_off != 8'd0) ? r_th_off - 8'd1 : 8'd0;
  assign w_th_add = sat_add(longint'(w_th_dec), longint'(ADAPT_STEP),
                            64'sd0, longint'(TH_OFF_MAX));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_th_off <= 8'd0;
    end else if (w_tick) begin
      r_th_off <= w_fire ? w_th_add[7:0] : w_th_dec;
    end
  end
`else
  assign w_thr = longint'(THRESH);
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= INTEG;
      r_v       <= '0;
      r_spike   <= 1'b0;
      r_led     <= 1'b0;
      r_refrac  <= '0;
      r_led_cnt <= '0;
    end else begin
      r_spike <= 1'b0;
      if (w_tick) begin
        case (r_state)
          INTEG: begin
            if (w_fire) begin
              r_v     <= V_RESET_V;
              r_spike <= 1'b1;
              if (HAS_REFRAC) begin
                r_state  <= REFRAC;
                r_refrac <= REFRAC_LD;
              end
            end else begin
              r_v <= w_v_next;
            end
          end
          REFRAC: begin
            r_v <= V_RESET_V;
            if (r_refrac <= RW'(1)) begin
              r_state  <= INTEG;
              r_refrac <= '0;
            end else begin
              r_refrac <= r_refrac - 1'b1;
            end
          end
          default: r_state <= INTEG;
        endcase

        // a spike reloads the hold counter even if the LED is already lit
        if (w_fire) begin
          r_led_cnt <= LED_LD;
          r_led     <= LED_ON;
        end else if (r_led_cnt != '0) begin
          r_led_cnt <= r_led_cnt - 1'b1;
          r_led     <= (r_led_cnt > LW'(1));
        end
      end
    end
  end

  assign v_mem = r_v;
  assign spike = r_spike;
  assign led   = r_led;

endmodule

// File: tb/tb_lif_neuron_n.sv
// tb/tb_lif_neuron_n.sv - directed self-checking bench for lif_neuron_n
module tb_lif_neuron_n;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  ex;
  logic [3:0]  inh;
  logic        spike;
  logic        led;
  logic [11:0] v_mem;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  lif_neuron_n dut (
    .clk   (clk),
    .reset (rst_n),
    .ex    (ex),
    .inh   (inh),
    .spike (spike),
    .led   (led),
    .v_mem (v_mem)
  );

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick_step;
    repeat (4) @(negedge clk);
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  int v2_exp [1:20] = '{24, 47, 69, 89, 0, 0, 0, 0, 0, 0,
                        24, 47, 69, 89, 0, 0, 0, 0, 0, 0};
  int v4_exp [1:11] = '{-32, -62, -90, -116, -140, -163, -184, -204, -223, -241, -256};

  initial begin
    rst_n = 1'b0;
    ex    = 4'b0000;
    inh   = 4'b0000;
    #1;
    chk("reset_v_mem", $signed(v_mem), 0);
    chk("reset_spike", spike, 0);
    chk("reset_led", led, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // quiet inputs
    for (int t = 1; t <= 50; t++) begin
      tick_step();
      chk("idle_v_mem", $signed(v_mem), 0);
      chk("idle_spike", spike, 0);
      chk("idle_led", led, 0);
    end

    // excitation, first-tick latency, fire, refractory, LED hold and retrigger
    do_reset();
    ex = 4'b1110;
    repeat (3) @(negedge clk);
    chk("exc_before_first_tick", $signed(v_mem), 0);
    @(negedge clk);
    chk("exc_tick1_v_mem", $signed(v_mem), v2_exp[1]);
    for (int t = 2; t <= 20; t++) begin
      @(negedge clk);
      if (t == 6) chk("exc_spike_one_clk", spike, 0);
      repeat (3) @(negedge clk);
      chk("exc_v_mem", $signed(v_mem), v2_exp[t]);
      chk("exc_spike", spike, (t == 5 || t == 15) ? 1 : 0);
      chk("exc_led", led, ((t >= 5 && t <= 12) || t >= 15) ? 1 : 0);
    end

    // balanced excitation and inhibition
    do_reset();
    ex  = 4'b0111;
    inh = 4'b0111;
    for (int t = 1; t <= 100; t++) begin
      tick_step();
      chk("bal_v_mem", $signed(v_mem), 0);
      chk("bal_spike", spike, 0);
    end

    // inhibition down to the lower saturation bound
    do_reset();
    ex  = 4'b0000;
    inh = 4'b1111;
    for (int t = 1; t <= 16; t++) begin
      tick_step();
      chk("inh_v_mem", $signed(v_mem), (t <= 11) ? v4_exp[t] : -256);
    end

    // reset during the refractory period
    do_reset();
    inh = 4'b0000;
    ex  = 4'b1110;
    repeat (7) tick_step();
    chk("rst_led_before", led, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_async_v_mem", $signed(v_mem), 0);
    chk("rst_async_led", led, 0);
    chk("rst_async_spike", spike, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick_step();
    chk("rst_after_v_mem_1", $signed(v_mem), 24);
    chk("rst_after_spike", spike, 0);
    chk("rst_after_led", led, 0);
    tick_step();
    chk("rst_after_v_mem_2", $signed(v_mem), 47);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
